// File: rtl/ysyx_22041412_csr_ctrl.sv
// ysyx_22041412_csr_ctrl
// Sequencer between the EXU and the machine-mode CSR file. Runs one CSR
// instruction, ECALL, MRET or timer-interrupt trap at a time through the
// CSR file en/addr/func3/data handshake. CSR instructions get an extra
// write-back cycle. Read data goes back to the EXU; traps and MRET issue
// a PC redirect.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   req_*               EXU request (valid/ready, op, CSR index, funct3, data, pc)
//   irq_i, irq_pc_i     timer interrupt level and PC to save as mepc
//   mie_i               mstatus.MIE from the CSR file
//   csr_*               CSR file handshake (en/addr/func3/wdata/pc, rdata/ready)
//   resp_valid_o/rdata  1-cycle completion pulse with old CSR value
//   redir_valid_o/pc    1-cycle redirect pulse with target PC
//   err_o               1-cycle pulse on illegal request or CSR timeout
//
// state | meaning
// IDLE  | waiting for irq (priority) or request
// ACC   | csr_en_o high, waiting for csr_ready_i
// WB    | one more enable cycle so the CSR file commits the write
// RESP  | completion/redirect pulse, csr_en_o low
// ERR   | err_o pulse
module ysyx_22041412_csr_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [2:0]      req_addr_i,
  input  logic [2:0]      req_func3_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [XLEN-1:0] req_pc_i,
  input  logic            irq_i,
  input  logic [XLEN-1:0] irq_pc_i,
  input  logic            mie_i,
  output logic            csr_en_o,
  output logic [2:0]      csr_addr_o,
  output logic [2:0]      csr_func3_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic [XLEN-1:0] csr_pc_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  input  logic            csr_ready_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  output logic            err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ACC, WB, RESP, ERR} state_t;

  state_t          state;
  logic [1:0]      op;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] data;

  logic            take_irq;
  logic            accept;
  logic            illegal;
  logic            done;
  logic [XLEN-1:0] done_data;

  // An enabled interrupt steals the IDLE cycle, so the EXU must not see ready.
  assign take_irq    = (state == IDLE) && irq_i && mie_i;
  assign req_ready_o = (state == IDLE) && !(irq_i && mie_i);
  assign accept      = req_valid_i && req_ready_o;
  assign illegal     = (req_op_i == 2'd3) ||
                       ((req_op_i == 2'd0) && ((req_func3_i == 3'b000) || (req_func3_i == 3'b100)));

  // ECALL/MRET carry func3=000 and skip WB; the RESP entry then takes the live
  // read data instead of the captured copy.
  assign done      = ((state == ACC) && csr_ready_i && (csr_func3_o == 3'b000)) || (state == WB);
  assign done_data = (state == WB) ? data : csr_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op            <= 2'd0;
      cnt           <= '0;
      data          <= '0;
      csr_en_o      <= 1'b0;
      csr_addr_o    <= 3'd0;
      csr_func3_o   <= 3'd0;
      csr_wdata_o   <= '0;
      csr_pc_o      <= '0;
      resp_valid_o  <= 1'b0;
      resp_rdata_o  <= '0;
      redir_valid_o <= 1'b0;
      redir_pc_o    <= '0;
      err_o         <= 1'b0;
    end else begin
      resp_valid_o  <= 1'b0;
      resp_rdata_o  <= '0;
      redir_valid_o <= 1'b0;
      redir_pc_o    <= '0;
      err_o         <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (take_irq) begin
            state       <= ACC;
            op          <= 2'd1;
            csr_en_o    <= 1'b1;
            csr_addr_o  <= 3'd1;
            csr_func3_o <= 3'b000;
            csr_wdata_o <= '0;
            csr_pc_o    <= irq_pc_i;
          end else if (accept) begin
            if (illegal) begin
              state <= ERR;
              err_o <= 1'b1;
            end else begin
              state       <= ACC;
              op          <= req_op_i;
              csr_en_o    <= 1'b1;
              csr_addr_o  <= (req_op_i == 2'd0) ? req_addr_i :
                             (req_op_i == 2'd1) ? 3'd1 : 3'd0;
              csr_func3_o <= (req_op_i == 2'd0) ? req_func3_i : 3'b000;
              csr_wdata_o <= req_wdata_i;
              csr_pc_o    <= req_pc_i;
            end
          end
        end
        ACC: begin
          if (csr_ready_i) begin
            data <= csr_rdata_i;
            if (csr_func3_o != 3'b000) state <= WB;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state    <= ERR;
            err_o    <= 1'b1;
            csr_en_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB:      ;
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done) begin
        state    <= RESP;
        csr_en_o <= 1'b0;
        if (op == 2'd0) begin
          resp_valid_o <= 1'b1;
          resp_rdata_o <= done_data;
        end else begin
          redir_valid_o <= 1'b1;
          redir_pc_o    <= done_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_csr_ctrl.sv
module tb_ysyx_22041412_csr_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_op_i;
  logic [2:0]  req_addr_i, req_func3_i;
  logic [63:0] req_wdata_i, req_pc_i;
  logic        irq_i, mie_i;
  logic [63:0] irq_pc_i;
  logic        csr_en_o;
  logic [2:0]  csr_addr_o, csr_func3_o;
  logic [63:0] csr_wdata_o, csr_pc_o, csr_rdata_i;
  logic        csr_ready_i;
  logic        resp_valid_o, redir_valid_o, err_o;
  logic [63:0] resp_rdata_o, redir_pc_o;

  always #5 clk = ~clk;

  ysyx_22041412_csr_ctrl #(.XLEN(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_func3_i(req_func3_i), .req_wdata_i(req_wdata_i),
    .req_pc_i(req_pc_i), .irq_i(irq_i), .irq_pc_i(irq_pc_i), .mie_i(mie_i),
    .csr_en_o(csr_en_o), .csr_addr_o(csr_addr_o), .csr_func3_o(csr_func3_o),
    .csr_wdata_o(csr_wdata_o), .csr_pc_o(csr_pc_o), .csr_rdata_i(csr_rdata_i),
    .csr_ready_i(csr_ready_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o), .err_o(err_o)
  );

  // CSR file model: ready follows enable by one cycle; the first enabled+ready
  // cycle reads (and performs ECALL side effects), the second commits the write.
  logic        stuck;
  logic        ready_q, seen;
  logic [63:0] mstatus, mtvec, mepc, mcause, nxt;

  assign csr_ready_i = ready_q && !stuck;

  always_comb begin
    case (csr_addr_o)
      3'd0:    csr_rdata_i = mepc;
      3'd1:    csr_rdata_i = mtvec;
      3'd2:    csr_rdata_i = mstatus;
      3'd3:    csr_rdata_i = mtvec;
      3'd4:    csr_rdata_i = mepc;
      3'd5:    csr_rdata_i = mcause;
      default: csr_rdata_i = 64'd0;
    endcase
    case (csr_func3_o[1:0])
      2'b01:   nxt = csr_wdata_o;
      2'b10:   nxt = csr_rdata_i | csr_wdata_o;
      2'b11:   nxt = csr_rdata_i & ~csr_wdata_o;
      default: nxt = csr_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      seen    <= 1'b0;
      mstatus <= 64'ha00001800;
      mtvec   <= 64'd0;
      mepc    <= 64'd0;
      mcause  <= 64'd0;
    end else begin
      ready_q <= csr_en_o;
      if (!csr_en_o) begin
        seen <= 1'b0;
      end else if (csr_ready_i) begin
        if (!seen) begin
          seen <= 1'b1;
          if (csr_func3_o == 3'b000 && csr_addr_o == 3'd1) begin
            mepc   <= csr_pc_o;
            mcause <= 64'hb;
          end
        end else if (csr_func3_o != 3'b000) begin
          case (csr_addr_o)
            3'd2:    mstatus <= nxt;
            3'd3:    mtvec   <= nxt;
            3'd4:    mepc    <= nxt;
            3'd5:    mcause  <= nxt;
            default: ;
          endcase
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  int en_cyc, enr_cyc, resp_n, redir_n, err_n, acc_k, lat;
  logic [63:0] rd, rpc;

  // Watch ncyc cycles starting at a negedge; drops req_valid after acceptance
  // and measures latency from the accepting edge to the first pulse.
  task automatic observe(input int ncyc, input bit have_acc, input int acc0);
    bit drop;
    bit got;
    drop = 0; got = have_acc; acc_k = acc0; lat = -1;
    en_cyc = 0; enr_cyc = 0; resp_n = 0; redir_n = 0; err_n = 0; rd = 0; rpc = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (drop) req_valid_i = 1'b0;
      drop = 0;
      #1;
      if (req_valid_i && req_ready_o) begin
        drop = 1;
        if (!got) begin got = 1; acc_k = k; end
      end
      if (csr_en_o) en_cyc++;
      if (csr_en_o && csr_ready_i) enr_cyc++;
      if (resp_valid_o) begin resp_n++; rd = resp_rdata_o; end
      if (redir_valid_o) begin redir_n++; rpc = redir_pc_o; end
      if (err_o) err_n++;
      if ((resp_valid_o || redir_valid_o || err_o) && lat < 0 && got) lat = k - acc_k;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [2:0] addr, input logic [2:0] f3,
                        input logic [63:0] wd, input logic [63:0] pc, input int ncyc);
    req_op_i = op; req_addr_i = addr; req_func3_i = f3; req_wdata_i = wd; req_pc_i = pc;
    req_valid_i = 1'b1;
    observe(ncyc, 0, 0);
  endtask

  initial begin
    int wb_hits;
    bit found;
    req_valid_i = 0; req_op_i = 0; req_addr_i = 0; req_func3_i = 0;
    req_wdata_i = 0; req_pc_i = 0; irq_i = 0; irq_pc_i = 0; mie_i = 0; stuck = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_en", {63'd0, csr_en_o}, 64'd0);
    chk("rst_pulses", {61'd0, resp_valid_o, redir_valid_o, err_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 3'd2, 3'b001, 64'h8, 64'h80000000, 12);
    chk("csrrw_rd", rd, 64'ha00001800);
    chk("csrrw_resp_n", 64'(resp_n), 64'd1);
    chk("csrrw_en_cyc", 64'(en_cyc), 64'd3);
    chk("csrrw_en_rdy", 64'(enr_cyc), 64'd2);
    chk("csrrw_lat", 64'(lat), 64'd4);
    chk("csrrw_redir", 64'(redir_n), 64'd0);
    chk("mstatus_w", mstatus, 64'h8);

    run_op(2'd0, 3'd2, 3'b010, 64'h0, 64'h80000004, 12);
    chk("csrrs_rd", rd, 64'h8);

    run_op(2'd0, 3'd3, 3'b001, 64'h80001000, 64'h80000008, 12);
    chk("mtvec_old", rd, 64'h0);
    chk("mtvec_w", mtvec, 64'h80001000);

    run_op(2'd0, 3'd2, 3'b011, 64'h8, 64'h8000000c, 12);
    chk("csrrc_rd", rd, 64'h8);
    chk("csrrc_w", mstatus, 64'h0);

    run_op(2'd1, 3'd0, 3'b000, 64'h0, 64'h80000010, 12);
    chk("ecall_redir_n", 64'(redir_n), 64'd1);
    chk("ecall_pc", rpc, 64'h80001000);
    chk("ecall_resp_n", 64'(resp_n), 64'd0);
    chk("ecall_lat", 64'(lat), 64'd3);
    chk("ecall_en_cyc", 64'(en_cyc), 64'd2);
    chk("ecall_mepc", mepc, 64'h80000010);
    chk("ecall_mcause", mcause, 64'hb);

    run_op(2'd2, 3'd0, 3'b000, 64'h0, 64'h80001040, 12);
    chk("mret_pc", rpc, 64'h80000010);
    chk("mret_redir_n", 64'(redir_n), 64'd1);
    chk("mret_resp_n", 64'(resp_n), 64'd0);
    chk("mret_en_cyc", 64'(en_cyc), 64'd2);
    chk("mret_lat", 64'(lat), 64'd3);

    // Interrupt masked: the request goes through normally.
    irq_i = 1'b1; mie_i = 1'b0; irq_pc_i = 64'h80000400;
    #1;
    chk("irq_masked_ready", {63'd0, req_ready_o}, 64'd1);
    run_op(2'd0, 3'd5, 3'b010, 64'h0, 64'h80000020, 12);
    chk("irq_masked_rd", rd, 64'hb);
    chk("irq_masked_redir", 64'(redir_n), 64'd0);
    chk("irq_masked_resp", 64'(resp_n), 64'd1);
    irq_i = 1'b0;

    // Interrupt enabled with a pending request: trap first, then the request.
    req_op_i = 2'd0; req_addr_i = 3'd2; req_func3_i = 3'b110; req_wdata_i = 64'h5;
    req_pc_i = 64'h80000024; req_valid_i = 1'b1; irq_i = 1'b1; mie_i = 1'b1;
    #1;
    chk("irq_ready_low", {63'd0, req_ready_o}, 64'd0);
    @(posedge clk);
    #1;
    irq_i = 1'b0; mie_i = 1'b0;
    @(negedge clk);
    observe(20, 1, -1);
    chk("irq_redir_n", 64'(redir_n), 64'd1);
    chk("irq_redir_pc", rpc, 64'h80001000);
    chk("irq_lat", 64'(lat), 64'd3);
    chk("irq_mepc", mepc, 64'h80000400);
    chk("irq_then_req", 64'(resp_n), 64'd1);
    chk("irq_req_rd", rd, 64'h0);
    chk("csrrsi_w", mstatus, 64'h5);

    stuck = 1'b1;
    run_op(2'd0, 3'd2, 3'b010, 64'h0, 64'h80000030, 24);
    chk("tmo_err_n", 64'(err_n), 64'd1);
    chk("tmo_en_cyc", 64'(en_cyc), 64'd16);
    chk("tmo_lat", 64'(lat), 64'd17);
    chk("tmo_resp_n", 64'(resp_n), 64'd0);
    stuck = 1'b0;

    run_op(2'd0, 3'd2, 3'b100, 64'h1, 64'h80000034, 8);
    chk("f3_100_err", 64'(err_n), 64'd1);
    chk("f3_100_en", 64'(en_cyc), 64'd0);
    chk("f3_100_lat", 64'(lat), 64'd1);
    chk("f3_100_mstatus", mstatus, 64'h5);

    run_op(2'd3, 3'd2, 3'b001, 64'h1, 64'h80000038, 8);
    chk("op3_err", 64'(err_n), 64'd1);
    chk("op3_en", 64'(en_cyc), 64'd0);

    // Reset asserted in the write-back cycle.
    req_op_i = 2'd0; req_addr_i = 3'd2; req_func3_i = 3'b001; req_wdata_i = 64'h55;
    req_pc_i = 64'h80000040; req_valid_i = 1'b1;
    wb_hits = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (csr_en_o && csr_ready_i) wb_hits++;
      if (wb_hits == 2) found = 1;
      else begin
        @(negedge clk);
        if (!req_ready_o) req_valid_i = 1'b0;
      end
    end
    chk("reach_wb", {63'd0, found}, 64'd1);
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", {63'd0, csr_en_o}, 64'd0);
    chk("rst_mid_addr", {61'd0, csr_addr_o}, 64'd0);
    chk("rst_mid_ready", {63'd0, req_ready_o}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    observe(12, 0, 0);
    chk("post_rst_pulses", 64'(resp_n + redir_n + err_n), 64'd0);
    chk("post_rst_en", 64'(en_cyc), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
